sbp_pipeline_injector: RTL

- Head-of-pipeline source for the scalable pipelined lookup: generates the per-stage input bundle (ip_addr, bit_pos, stage_id, location, result, update) that the first lookup stage consumes.
- Merges a lookup request stream and a buffered update (prefix write) stream into one slot per clock.
- Canonicalises update prefixes and enforces bounded update bursts so lookups are never starved.

---
 rtl/sbp_pkg.sv | 46 ++++
 rtl/sbp_sync_fifo.sv | 47 ++++
 rtl/sbp_pipeline_injector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sbp_pkg.sv
// Shared types and constants for the scalable pipelined lookup: field widths,
// the update entry carried from the injector to the stages, and prefix masking.
package sbp_pkg;

  localparam int ADDR_BITS     = 32;
  localparam int LEN_BITS      = 6;
  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;

  // Zero bits needed to round a field up to a whole nibble.
  function automatic int nibble_pad(input int w);
    return (4 - (w % 4)) % 4;
  endfunction

  localparam int PAD_BITS = nibble_pad(STAGE_ID_BITS) + nibble_pad(LOCATION_BITS);

  // Result word: padded stage id, padded location, one nibble of child L/R flags.
  function automatic int result_bits(input int stage_bits, input int loc_bits);
    return stage_bits + nibble_pad(stage_bits) + loc_bits + nibble_pad(loc_bits) + 4;
  endfunction

  localparam int RESULT_BITS = result_bits(STAGE_ID_BITS, LOCATION_BITS);

  localparam logic [STAGE_ID_BITS-1:0] ROOT_STAGE_ID = STAGE_ID_BITS'(1);

  typedef struct packed {
    logic [ADDR_BITS-1:0]     prefix;
    logic [LEN_BITS-1:0]      len;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } upd_entry_t;

  // Lengths above the address width saturate to a full mask.
  function automatic logic [ADDR_BITS-1:0] prefix_mask(input logic [LEN_BITS-1:0] len);
    logic [ADDR_BITS-1:0] m;
    if (len == '0)
      m = '0;
    else if (len >= LEN_BITS'(ADDR_BITS))
      m = '1;
    else
      m = {ADDR_BITS{1'b1}} << (LEN_BITS'(ADDR_BITS) - len);
    return m;
  endfunction

endpackage

// File: rtl/sbp_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes while full and pops while
// empty are ignored, so a full FIFO never accepts even when it pops that cycle.
module sbp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sbp_pipeline_injector.sv
// Head of the lookup pipeline: merges lookups and buffered prefix updates into
// one registered slot per clock, with update bursts bounded while lookups wait.
module sbp_pipeline_injector #(
  parameter int STAGE_ID_BITS  = sbp_pkg::STAGE_ID_BITS,
  parameter int LOCATION_BITS  = sbp_pkg::LOCATION_BITS,
  parameter int RESULT_BITS    = sbp_pkg::RESULT_BITS,
  parameter logic [STAGE_ID_BITS-1:0] ROOT_STAGE_ID = STAGE_ID_BITS'(sbp_pkg::ROOT_STAGE_ID),
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int MAX_UPD_BURST  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [31:0]              lkp_ip_addr_i,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [31:0]              upd_prefix_i,
  input  logic [5:0]               upd_prefix_len_i,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] upd_location_i,
  input  logic [RESULT_BITS-1:0]   upd_result_i,
  input  logic                     upd_hold_i,
  output logic                     valid_o,
  output logic                     update_o,
  output logic [31:0]              ip_addr_o,
  output logic [5:0]               bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,
  output logic [15:0]              upd_issued_o,
  output logic [15:0]              lkp_issued_o
);

  import sbp_pkg::*;

  localparam int BW = $clog2(MAX_UPD_BURST + 1);

  typedef struct packed {
    logic [31:0]              prefix;
    logic [5:0]               len;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } entry_t;

  entry_t w_push_entry;
  entry_t w_head;
  logic   w_fifo_full;
  logic   w_fifo_empty;
  logic   w_upd_pend;
  logic   w_upd_slot;
  logic   w_lkp_slot;
  logic [5:0] w_head_len;

  logic                     r_valid;
  logic                     r_update;
  logic [31:0]              r_ip_addr;
  logic [5:0]               r_bit_pos;
  logic [STAGE_ID_BITS-1:0] r_stage_id;
  logic [LOCATION_BITS-1:0] r_location;
  logic [RESULT_BITS-1:0]   r_result;
  logic [15:0]              r_upd_cnt;
  logic [15:0]              r_lkp_cnt;
  logic [BW-1:0]            r_burst_cnt;

  assign w_push_entry = '{prefix:   upd_prefix_i,
                          len:      upd_prefix_len_i,
                          stage_id: upd_stage_id_i,
                          location: upd_location_i,
                          result:   upd_result_i};

  sbp_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (UPD_FIFO_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (upd_valid_i),
    .i_data  (w_push_entry),
    .i_pop   (w_upd_slot),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Arbitration sees only registered FIFO state, so update valid never feeds ready.
  assign w_upd_pend  = !w_fifo_empty && !upd_hold_i;
  assign w_upd_slot  = w_upd_pend && (!lkp_valid_i || (r_burst_cnt < BW'(MAX_UPD_BURST)));
  assign w_lkp_slot  = !w_upd_slot && lkp_valid_i;
  assign lkp_ready_o = w_lkp_slot;
  assign upd_ready_o = !w_fifo_full;
  assign w_head_len  = (w_head.len > 6'd32) ? 6'd32 : w_head.len;

  // NOTE: every register here uses <=, so all of them see pre-edge values of each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_update    <= 1'b0;
      r_ip_addr   <= '0;
      r_bit_pos   <= '0;
      r_stage_id  <= '0;
      r_location  <= '0;
      r_result    <= '0;
      r_upd_cnt   <= '0;
      r_lkp_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      if (w_upd_slot) begin
        r_valid    <= 1'b1;
        r_update   <= 1'b1;
        r_ip_addr  <= w_head.prefix & prefix_mask(w_head.len);
        r_bit_pos  <= w_head_len;
        r_stage_id <= w_head.stage_id;
        r_location <= w_head.location;
        r_result   <= w_head.result;
        r_upd_cnt  <= r_upd_cnt + 16'd1;
      end else if (w_lkp_slot) begin
        r_valid    <= 1'b1;
        r_update   <= 1'b0;
        r_ip_addr  <= lkp_ip_addr_i;
        r_bit_pos  <= '0;
        r_stage_id <= ROOT_STAGE_ID;
        r_location <= '0;
        r_result   <= '0;
        r_lkp_cnt  <= r_lkp_cnt + 16'd1;
      end else begin
        r_valid    <= 1'b0;
        r_update   <= 1'b0;
        r_stage_id <= '0;
      end

      if (!lkp_valid_i || w_lkp_slot)
        r_burst_cnt <= '0;
      else if (w_upd_slot && (r_burst_cnt < BW'(MAX_UPD_BURST)))
        r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  assign valid_o      = r_valid;
  assign update_o     = r_update;
  assign ip_addr_o    = r_ip_addr;
  assign bit_pos_o    = r_bit_pos;
  assign stage_id_o   = r_stage_id;
  assign location_o   = r_location;
  assign result_o     = r_result;
  assign upd_issued_o = r_upd_cnt;
  assign lkp_issued_o = r_lkp_cnt;

endmodule
